ras_ctrl: RTL and testbench
===========================

# ras_ctrl

Speculation controller that sits directly upstream of the return address stack. It turns decoded fetch-side call/return/branch events and in-order branch resolutions into the stack's `push`/`pop`/`din` and per-level `commit`/`flush` pulses. It also tracks the number of outstanding speculation levels, up to `STAGES`, and back-pressures fetch when every level is in use.

## Interface
Parameters:
- `STAGES`, default 2: speculation levels; must match the stack's `STAGES`.
- `WIDTH`, default 32: PC / return-address width.
- `INSN_BYTES`, default 4: call instruction length added to the call PC.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `fe_valid`, in, 1: fetch beat valid.
- `fe_ready`, out, 1: controller accepts the beat.
- `fe_call`, in, 1: the beat is a call. Mutually exclusive with `fe_ret`.
- `fe_ret`, in, 1: the beat is a return.
- `fe_branch`, in, 1: the beat opens a new speculation level. May coincide with call or ret.
- `fe_pc`, in, `WIDTH`: PC of the beat.
- `rs_valid`, in, 1: the oldest outstanding branch resolves this cycle.
- `rs_mispredict`, in, 1: qualifies `rs_valid`; 1 means mispredicted.
- `push`, out, 1: stack push.
- `pop`, out, 1: stack pop.
- `din`, out, `WIDTH`: return address for `push`.
- `commit`, out, `STAGES`: one-hot level commit pulse.
- `flush`, out, `STAGES`: one-hot level flush pulse.
- `depth`, out, `$clog2(STAGES+1)`: outstanding speculation levels.

## Operation
- **Accept condition.** A beat is accepted when `fe_valid && fe_ready`.
  - `fe_ready = !reset && (depth < STAGES || (rs_valid && !rs_mispredict))`.
  - If `rs_valid && rs_mispredict`, `fe_ready` is forced to 0 in that cycle.
- **Stack operations.**
  - Accepted call: `push=1`, `din = fe_pc + INSN_BYTES`, computed modulo 2^`WIDTH`.
  - Accepted ret: `pop=1`; `din` holds its previous value.
  - Other beats produce no stack operation.
- **Depth counter.** Let `open` be an accepted beat with `fe_branch`, and `res` be `rs_valid`. Next `depth`:
  - `res && rs_mispredict`: 0. Any same-cycle fetch is ignored.
  - `open && !res`: `depth+1`.
  - `res && !open`: `depth-1`.
  - `open && res` (correct prediction): unchanged.
  - Otherwise: unchanged.
- **Commit and flush level.**
  - A correct resolution pulses `commit[depth-1]`.
  - A misprediction pulses `flush[depth-1]`, using `depth` as sampled in the resolution cycle.
  - A flush discards all younger levels; no separate flushes are issued for them.
- **Errors.**
  - `rs_valid` while `depth==0` is a protocol error: no pulse, `depth` stays 0.
  - An assertion fires in simulation.
- **Same-beat ordering.** When a call or ret has `fe_branch` set, the push/pop belongs to the level that is current before the new level opens.

## Timing
- All outputs except `fe_ready` are registered: an event in cycle t appears at cycle t+1 for exactly one cycle.
  - Applies to `push`, `pop`, `commit`, `flush`.
  - `depth` updates at t+1.
- `fe_ready` is combinational from `depth`, `rs_valid`, `rs_mispredict` and `reset`.
- The stack samples `push`/`pop` and `commit`/`flush` in the same cycle. At t+1, `commit` or `flush` together with a `push`/`pop` is legal, with this ordering:
  - A commit applies after the push/pop, so the op belongs to the pre-shift level.
  - A flush cancels the op: when `flush` is 1 at t+1, `push` and `pop` are 0 at t+1.
- **Reset.** Values while `reset` is high and in the cycle after:
  - `push`, `pop`, `commit`, `flush`, `depth`, `din` are 0.
  - `fe_ready` is 0 while `reset` is high.
  - Reset mid-speculation discards every level with no pulse.
- **Back-pressure.** At `depth==STAGES` with no correct resolution, `fe_ready=0`. The upstream must hold its beat stable.

## Structure
- Shared `ras_pkg` holds:
  - `ras_op_e` (`RAS_NONE`, `RAS_PUSH`, `RAS_POP`);
  - `RAS_STAGES` and `RAS_WIDTH` defaults;
  - function `ret_addr(pc)`.
- The stack consumes `ras_pkg` too, so the level count stays consistent.
- No sub-module: a single flat module with one depth counter and one output register bank.

## Test plan
1. **Call then ret.** Reset, then call at `fe_pc=0x100`.
   - Next cycle: `push=1`, `din=0x104`.
   - Ret the following cycle: `pop=1`, `depth=0`.
2. **Fill and stall.** With `STAGES=2`, two accepted branches give `depth=2` and `fe_ready=0`.
   - Then correct `rs_valid`: `commit[1]` pulses.
   - `fe_ready` was 1 in the resolve cycle.
3. **Misprediction.** From `depth=2`, mispredict with a same-cycle valid call.
   - `fe_ready=0`.
   - Next cycle: `flush[1]=1`, `push=0`, `depth=0`.
4. **Branch plus resolve.** Branch and correct resolve in the same cycle at `depth=1`.
   - `commit[0]=1`.
   - `depth` stays 1.
5. **PC wrap.** Call at `fe_pc=0xFFFF_FFFE` gives `din=0x0000_0002`.
6. **Mid-speculation reset.** Reset asserted at `depth=2` with a pending call.
   - No `push`, `commit` or `flush` follows.
   - `depth=0` the cycle after reset.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared definitions for the return-address-stack speculation path.
// Consumed by ras_ctrl and by the stack itself so both agree on level count and width.
package ras_pkg;

  // Stack operation requested for one fetch beat.
  typedef enum logic [1:0] {
    RAS_NONE = 2'd0,
    RAS_PUSH = 2'd1,
    RAS_POP  = 2'd2
  } ras_op_e;

  localparam int unsigned RAS_STAGES     = 2;
  localparam int unsigned RAS_WIDTH      = 32;
  localparam int unsigned RAS_INSN_BYTES = 4;

  // Return address of a call at pc; wraps modulo 2^RAS_WIDTH.
  function automatic logic [RAS_WIDTH-1:0] ret_addr(input logic [RAS_WIDTH-1:0] pc);
    return pc + RAS_WIDTH'(RAS_INSN_BYTES);
  endfunction

endpackage

// File: rtl/ras_ctrl.sv
// Speculation controller in front of the return address stack.
// Turns fetch call/ret/branch beats and in-order branch resolutions into stack
// push/pop/din and per-level commit/flush pulses, and tracks outstanding levels.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   fe_valid/fe_ready   - fetch beat handshake (fe_ready is combinational)
//   fe_call/fe_ret      - beat is a call / return (mutually exclusive)
//   fe_branch           - beat opens a new speculation level
//   fe_pc               - PC of the beat
//   rs_valid            - oldest outstanding branch resolves this cycle
//   rs_mispredict       - resolution was a misprediction
//   push/pop/din        - registered stack operation and return address
//   commit/flush        - registered one-hot level pulses
//   depth               - outstanding speculation levels
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int unsigned STAGES     = RAS_STAGES,
  parameter int unsigned WIDTH      = RAS_WIDTH,
  parameter int unsigned INSN_BYTES = RAS_INSN_BYTES,
  localparam int unsigned DW        = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fe_valid,
  output logic              fe_ready,
  input  logic              fe_call,
  input  logic              fe_ret,
  input  logic              fe_branch,
  input  logic [WIDTH-1:0]  fe_pc,
  input  logic              rs_valid,
  input  logic              rs_mispredict,
  output logic              push,
  output logic              pop,
  output logic [WIDTH-1:0]  din,
  output logic [STAGES-1:0] commit,
  output logic [STAGES-1:0] flush,
  output logic [DW-1:0]     depth
);

  ras_op_e             op_d, op_q;
  logic [WIDTH-1:0]    din_d, din_q;
  logic [STAGES-1:0]   commit_d, commit_q;
  logic [STAGES-1:0]   flush_d, flush_q;
  logic [DW-1:0]       depth_d, depth_q;

  logic                mispredict;
  logic                accept;
  logic                open;
  logic                res_ok;
  logic [STAGES-1:0]   cur_level;

  // A misprediction squashes fetch outright so the flush never coexists with a stack op.
  assign mispredict = rs_valid && rs_mispredict;
  assign fe_ready   = !reset && !mispredict && ((depth_q < DW'(STAGES)) || rs_valid);
  assign accept     = fe_valid && fe_ready;
  assign open       = accept && fe_branch;
  // Resolution with no outstanding level is a protocol error and is ignored.
  assign res_ok     = rs_valid && (depth_q != '0);

  // One-hot of the youngest outstanding level, depth_q-1.
  always_comb begin
    cur_level = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      cur_level[i] = (depth_q == DW'(i + 1));
    end
  end

  always_comb begin
    op_d     = RAS_NONE;
    din_d    = din_q;
    commit_d = '0;
    flush_d  = '0;
    depth_d  = depth_q;

    if (accept && fe_call) begin
      op_d  = RAS_PUSH;
      din_d = fe_pc + WIDTH'(INSN_BYTES);
    end else if (accept && fe_ret) begin
      op_d  = RAS_POP;
    end

    if (rs_valid) begin
      if (!res_ok) begin
        depth_d = '0;
      end else if (rs_mispredict) begin
        flush_d = cur_level;
        depth_d = '0;
      end else begin
        commit_d = cur_level;
        // A same-cycle new level replaces the retiring one.
        if (!open) begin
          depth_d = depth_q - DW'(1);
        end
      end
    end else if (open) begin
      depth_d = depth_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= RAS_NONE;
      din_q    <= '0;
      commit_q <= '0;
      flush_q  <= '0;
      depth_q  <= '0;
    end else begin
      op_q     <= op_d;
      din_q    <= din_d;
      commit_q <= commit_d;
      flush_q  <= flush_d;
      depth_q  <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rs_valid) begin
      assert (depth_q != '0)
        else $error("ras_ctrl: resolution with no outstanding speculation level");
    end
  end

  assign push   = (op_q == RAS_PUSH);
  assign pop    = (op_q == RAS_POP);
  assign din    = din_q;
  assign commit = commit_q;
  assign flush  = flush_q;
  assign depth  = depth_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: stimulus pushes expected pulse beats, a monitor
// pops and compares whenever the DUT shows push/pop/commit/flush activity.
module tb_ras_ctrl;

  localparam int unsigned STAGES = 2;
  localparam int unsigned WIDTH  = 32;

  typedef struct packed {
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [1:0]       commit;
    logic [1:0]       flush;
    logic [1:0]       depth;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              fe_valid, fe_ready, fe_call, fe_ret, fe_branch;
  logic [WIDTH-1:0]  fe_pc;
  logic              rs_valid, rs_mispredict;
  logic              push, pop;
  logic [WIDTH-1:0]  din;
  logic [STAGES-1:0] commit, flush;
  logic [1:0]        depth;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  ras_ctrl #(.STAGES(STAGES), .WIDTH(WIDTH), .INSN_BYTES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .fe_valid     (fe_valid),
    .fe_ready     (fe_ready),
    .fe_call      (fe_call),
    .fe_ret       (fe_ret),
    .fe_branch    (fe_branch),
    .fe_pc        (fe_pc),
    .rs_valid     (rs_valid),
    .rs_mispredict(rs_mispredict),
    .push         (push),
    .pop          (pop),
    .din          (din),
    .commit       (commit),
    .flush        (flush),
    .depth        (depth)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fe_valid = 0; fe_call = 0; fe_ret = 0; fe_branch = 0; fe_pc = '0;
    rs_valid = 0; rs_mispredict = 0;
  endtask

  task automatic expect_beat(input logic p, input logic o, input logic [WIDTH-1:0] d,
                             input logic [1:0] c, input logic [1:0] f, input logic [1:0] dp);
    exp_t e;
    e = '{push: p, pop: o, din: d, commit: c, flush: f, depth: dp};
    exp_q.push_back(e);
  endtask

  // Monitor: compare every beat with pulse activity against the queue head.
  always @(negedge clk) begin
    if (!reset && (push || pop || (|commit) || (|flush))) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got push=%0b pop=%0b commit=%b flush=%b expected none",
                 push, pop, commit, flush);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_push",   64'(push),   64'(e.push));
        check("mon_pop",    64'(pop),    64'(e.pop));
        check("mon_din",    64'(din),    64'(e.din));
        check("mon_commit", 64'(commit), 64'(e.commit));
        check("mon_flush",  64'(flush),  64'(e.flush));
        check("mon_depth",  64'(depth),  64'(e.depth));
      end
    end
  end

  initial begin
    idle();
    reset = 1;
    repeat (3) cyc();
    check("rst_ready", 64'(fe_ready), 64'd0);
    check("rst_depth", 64'(depth),    64'd0);
    check("rst_din",   64'(din),      64'd0);
    check("rst_push",  64'(push),     64'd0);
    reset = 0;
    #1;
    check("idle_ready", 64'(fe_ready), 64'd1);

    // Call then ret.
    fe_valid = 1; fe_call = 1; fe_pc = 32'h100;
    expect_beat(1, 0, 32'h104, 2'b00, 2'b00, 2'd0);
    cyc();
    fe_call = 0; fe_ret = 1;
    expect_beat(0, 1, 32'h104, 2'b00, 2'b00, 2'd0);
    cyc();
    idle();

    // Fill and stall.
    fe_valid = 1; fe_branch = 1;
    cyc();
    check("fill_depth1", 64'(depth), 64'd1);
    cyc();
    check("fill_depth2", 64'(depth), 64'd2);
    idle();
    #1;
    check("full_ready", 64'(fe_ready), 64'd0);
    rs_valid = 1;
    #1;
    check("resolve_ready", 64'(fe_ready), 64'd1);
    expect_beat(0, 0, 32'h104, 2'b10, 2'b00, 2'd1);
    cyc();
    idle();

    // Branch plus correct resolve at depth 1.
    fe_valid = 1; fe_branch = 1; rs_valid = 1;
    expect_beat(0, 0, 32'h104, 2'b01, 2'b00, 2'd1);
    cyc();
    idle();
    check("br_res_depth", 64'(depth), 64'd1);

    // Misprediction at depth 2 with a same-cycle call.
    fe_valid = 1; fe_branch = 1;
    cyc();
    idle();
    check("pre_mis_depth", 64'(depth), 64'd2);
    fe_valid = 1; fe_call = 1; fe_pc = 32'h200; rs_valid = 1; rs_mispredict = 1;
    #1;
    check("mis_ready", 64'(fe_ready), 64'd0);
    expect_beat(0, 0, 32'h104, 2'b00, 2'b10, 2'd0);
    cyc();
    idle();
    check("mis_depth", 64'(depth), 64'd0);

    // PC wrap on a call that also opens a level.
    fe_valid = 1; fe_call = 1; fe_branch = 1; fe_pc = 32'hFFFF_FFFE;
    expect_beat(1, 0, 32'h0000_0002, 2'b00, 2'b00, 2'd1);
    cyc();
    idle();

    // Ret with a correct resolve: pop and commit share the beat.
    fe_valid = 1; fe_ret = 1; rs_valid = 1;
    expect_beat(0, 1, 32'h0000_0002, 2'b01, 2'b00, 2'd0);
    cyc();
    idle();
    check("ret_res_depth", 64'(depth), 64'd0);

    // Mid-speculation reset with a pending call and resolve.
    fe_valid = 1; fe_branch = 1;
    cyc();
    cyc();
    idle();
    check("pre_rst_depth", 64'(depth), 64'd2);
    reset = 1; fe_valid = 1; fe_call = 1; fe_pc = 32'h300; rs_valid = 1;
    #1;
    check("midrst_ready", 64'(fe_ready), 64'd0);
    cyc();
    reset = 0;
    idle();
    check("midrst_depth", 64'(depth), 64'd0);
    check("midrst_din",   64'(din),   64'd0);
    repeat (3) cyc();
    check("post_rst_depth", 64'(depth), 64'd0);
    check("queue_drained",  64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
